// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner and its key-code FIFO.
package keypad_pkg;

    localparam int unsigned NUM_ROWS  = 4;
    localparam int unsigned NUM_COLS  = 4;
    localparam int unsigned KEYCODE_W = 4;

    typedef logic [KEYCODE_W-1:0]           keycode_t;
    typedef logic [NUM_ROWS*NUM_COLS-1:0]   keymap_t;

    // Index of the lowest set bit; 0 when the map is empty.
    function automatic keycode_t lowest_index(keymap_t map);
        keycode_t idx;
        idx = '0;
        for (int i = NUM_ROWS * NUM_COLS - 1; i >= 0; i--) begin
            if (map[i]) begin
                idx = keycode_t'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/key_fifo.sv
// First-word fall-through FIFO for key codes. The head is presented combinationally
// from storage while non-empty and holds its last shown value while empty.
module key_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 4
) (
    input  logic             clk_i,
    input  logic             srst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  rptr_q, rptr_d;
    logic [PtrW-1:0]  wptr_q, wptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [Width-1:0] hold_q, hold_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign data_o  = empty_o ? hold_q : mem_q[rptr_q];

    // Pointer/count bookkeeping; a pop frees a slot for a same-cycle push when full.
    always_comb begin
        do_pop  = pop_i & ~empty_o;
        do_push = push_i & (~full_o | do_pop);
        rptr_d  = do_pop  ? rptr_q + PtrW'(1) : rptr_q;
        wptr_d  = do_push ? wptr_q + PtrW'(1) : wptr_q;
        cnt_d   = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CntW'(1);
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - CntW'(1);
        end
        hold_d = empty_o ? hold_q : mem_q[rptr_q];
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!srst_ni) begin
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
            hold_q <= '0;
        end else begin
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
            cnt_q  <= cnt_d;
            hold_q <= hold_d;
        end
    end

    // Storage needs no reset: it is never shown while empty.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/keypad_scan_fifo.sv
// 4x4 keypad row scanner with full-map debounce and a key-code FIFO.
// Optional build macro KEYPAD_AUTOREPEAT_EN adds auto-repeat of a single held key.
module keypad_scan_fifo
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned DEBOUNCE_SCANS = 4,
    parameter int unsigned FIFO_DEPTH     = 4
`ifdef KEYPAD_AUTOREPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY   = 32,
    parameter int unsigned REPEAT_RATE    = 8
`endif
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NUM_COLS-1:0]  cols,
    output logic [NUM_ROWS-1:0]  rows,
    input  logic                 rd_en,
    input  logic                 clr_ovf,
    output logic [KEYCODE_W-1:0] key_code,
    output logic                 key_valid,
    output logic                 overflow
);

    localparam int unsigned DivW   = $clog2(SCAN_DIV);
    localparam int unsigned MatchW = $clog2(DEBOUNCE_SCANS + 1);

    logic [DivW-1:0]   div_q, div_d;
    logic [1:0]        row_q, row_d;
    keymap_t           snap_q, snap_d;
    keymap_t           cand_q, cand_d;
    keymap_t           stable_q, stable_d;
    keymap_t           new_press;
    logic [MatchW-1:0] match_q, match_d;
    logic              scan_done_q, scan_end;
    logic              push_q, push_d;
    keycode_t          push_code_q, push_code_d;
    logic              overflow_q, overflow_d;
    logic              fifo_full, fifo_empty, drop;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RepW   = $clog2(RepMax + 1);
    logic [RepW-1:0] rep_cnt_q, rep_cnt_d;
    logic            rep_armed_q, rep_armed_d;
`endif

    // Row divider and column sampling; the sample edge also advances the driven row.
    always_comb begin
        div_d    = div_q + DivW'(1);
        row_d    = row_q;
        snap_d   = snap_q;
        scan_end = 1'b0;
        if (div_q == DivW'(SCAN_DIV - 1)) begin
            div_d = '0;
            row_d = row_q + 2'd1;
            for (int c = 0; c < NUM_COLS; c++) begin
                snap_d[{row_q, 2'(c)}] = ~cols[c];
            end
            scan_end = (row_q == 2'd3);
        end
    end

    // Debounce the completed scan and stage at most one press event for the FIFO.
    always_comb begin
        cand_d      = cand_q;
        match_d     = match_q;
        stable_d    = stable_q;
        new_press   = '0;
        push_d      = 1'b0;
        push_code_d = push_code_q;
        if (scan_done_q) begin
            if (snap_q == cand_q) begin
                if (match_q != MatchW'(DEBOUNCE_SCANS)) begin
                    match_d = match_q + MatchW'(1);
                end
            end else begin
                cand_d  = snap_q;
                match_d = MatchW'(1);
            end
            if (match_d == MatchW'(DEBOUNCE_SCANS) && cand_d != stable_q) begin
                new_press = cand_d & ~stable_q;
                stable_d  = cand_d;
                if (new_press != '0) begin
                    push_d      = 1'b1;
                    push_code_d = lowest_index(new_press);
                end
            end
        end
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_cnt_d   = rep_cnt_q;
        rep_armed_d = rep_armed_q;
        if (scan_done_q) begin
            if (stable_d != stable_q || !$onehot(stable_q)) begin
                rep_cnt_d   = '0;
                rep_armed_d = 1'b0;
            end else if ((!rep_armed_q && rep_cnt_q == RepW'(REPEAT_DELAY - 1)) ||
                         (rep_armed_q && rep_cnt_q == RepW'(REPEAT_RATE - 1))) begin
                rep_cnt_d   = '0;
                rep_armed_d = 1'b1;
                push_d      = 1'b1;
                push_code_d = lowest_index(stable_q);
            end else begin
                rep_cnt_d = rep_cnt_q + RepW'(1);
            end
        end
`endif
    end

    // Sticky overflow; a dropped push wins over a same-cycle clear.
    always_comb begin
        drop       = push_q & fifo_full & ~(rd_en & ~fifo_empty);
        overflow_d = overflow_q;
        if (clr_ovf) begin
            overflow_d = 1'b0;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end
    end

    // Scanner, debounce and flag state with synchronous reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            div_q       <= '0;
            row_q       <= '0;
            snap_q      <= '0;
            cand_q      <= '0;
            stable_q    <= '0;
            match_q     <= '0;
            scan_done_q <= 1'b0;
            push_q      <= 1'b0;
            push_code_q <= '0;
            overflow_q  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt_q   <= '0;
            rep_armed_q <= 1'b0;
`endif
        end else begin
            div_q       <= div_d;
            row_q       <= row_d;
            snap_q      <= snap_d;
            cand_q      <= cand_d;
            stable_q    <= stable_d;
            match_q     <= match_d;
            scan_done_q <= scan_end;
            push_q      <= push_d;
            push_code_q <= push_code_d;
            overflow_q  <= overflow_d;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt_q   <= rep_cnt_d;
            rep_armed_q <= rep_armed_d;
`endif
        end
    end

    // One-hot active-low row drive follows the row register.
    always_comb begin
        rows = ~(4'b0001 << row_q);
    end

    key_fifo #(
        .Depth (FIFO_DEPTH),
        .Width (KEYCODE_W)
    ) u_key_fifo (
        .clk_i   (clk),
        .srst_ni (resetn),
        .push_i  (push_q),
        .data_i  (push_code_q),
        .pop_i   (rd_en),
        .data_o  (key_code),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign key_valid = ~fifo_empty;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Directed bench for keypad_scan_fifo with SCAN_DIV=4, DEBOUNCE_SCANS=2 (16-cycle scans).
module tb_keypad_scan_fifo;

    localparam int ScanCyc = 16;

    logic        clk = 1'b0;
    logic        resetn;
    logic [3:0]  cols;
    logic [3:0]  rows;
    logic        rd_en;
    logic        clr_ovf;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        overflow;
    logic [15:0] keys;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] keys;
        logic [3:0]  code;
    } vec_t;

    vec_t tbl[6];

    keypad_scan_fifo #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (2),
        .FIFO_DEPTH     (4)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .cols      (cols),
        .rows      (rows),
        .rd_en     (rd_en),
        .clr_ovf   (clr_ovf),
        .key_code  (key_code),
        .key_valid (key_valid),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a pressed key pulls its column low while its row is driven low.
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            cols[c] = 1'b1;
            for (int r = 0; r < 4; r++) begin
                if (!rows[r] && keys[r * 4 + c]) cols[c] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Leaves the bench at the negedge just after row 0 starts being driven.
    task automatic sync_scan();
        int n;
        n = 0;
        @(negedge clk);
        while (rows != 4'b0111 && n < 40) begin @(negedge clk); n++; end
        while (rows != 4'b1110 && n < 40) begin @(negedge clk); n++; end
        if (n >= 40) begin
            total++;
            bad++;
            $display("FAIL sync_scan: no row wrap seen within 40 cycles, rows=%b", rows);
        end
    endtask

    task automatic wait_scans(input int n);
        repeat (n * ScanCyc) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pop_check(input string name, input logic [3:0] exp);
        check({name, "_valid"}, 16'(key_valid), 16'd1);
        check({name, "_code"}, 16'(key_code), 16'(exp));
        rd_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic press_release(input logic [15:0] k);
        sync_scan();
        keys = k;
        wait_scans(4);
        keys = '0;
        wait_scans(4);
    endtask

    logic [3:0] exp_rows [5];

    initial begin
        tbl[0] = '{keys: 16'h0020, code: 4'h5};
        tbl[1] = '{keys: 16'h1008, code: 4'h3};
        tbl[2] = '{keys: 16'h8000, code: 4'hF};
        tbl[3] = '{keys: 16'h0001, code: 4'h0};
        tbl[4] = '{keys: 16'h0C00, code: 4'hA};
        tbl[5] = '{keys: 16'h4040, code: 4'h6};
        exp_rows[0] = 4'b1110;
        exp_rows[1] = 4'b1101;
        exp_rows[2] = 4'b1011;
        exp_rows[3] = 4'b0111;
        exp_rows[4] = 4'b1110;

        resetn  = 1'b0;
        keys    = '0;
        rd_en   = 1'b0;
        clr_ovf = 1'b0;

        // Reset state and row stepping
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rows", 16'(rows), 16'(exp_rows[0]));
        check("rst_valid", 16'(key_valid), 16'd0);
        check("rst_ovf", 16'(overflow), 16'd0);
        check("rst_code", 16'(key_code), 16'd0);
        resetn = 1'b1;
        for (int i = 1; i < 5; i++) begin
            repeat (4) @(posedge clk);
            @(negedge clk);
            check("row_step", 16'(rows), 16'(exp_rows[i]));
        end

        // Clean press of key 10 with exact latency: 2 scans + 2 cycles
        sync_scan();
        keys = 16'h0400;
        repeat (33) @(posedge clk);
        @(negedge clk);
        check("latency_early", 16'(key_valid), 16'd0);
        @(posedge clk);
        @(negedge clk);
        pop_check("clean_press", 4'hA);
        check("clean_popped", 16'(key_valid), 16'd0);
        wait_scans(4);
        check("held_no_repeat", 16'(key_valid), 16'd0);
        keys = '0;
        wait_scans(4);
        check("release_no_event", 16'(key_valid), 16'd0);
        // Pop while empty is ignored and the head value holds
        rd_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rd_en = 1'b0;
        check("empty_pop_valid", 16'(key_valid), 16'd0);
        check("empty_hold_code", 16'(key_code), 16'hA);

        // Bounce: key 5 in alternating scans, then steady
        for (int i = 0; i < 6; i++) begin
            sync_scan();
            keys = (i % 2 == 0) ? 16'h0020 : 16'h0000;
        end
        sync_scan();
        check("bounce_no_push", 16'(key_valid), 16'd0);
        keys = 16'h0020;
        wait_scans(4);
        pop_check("bounce_steady", 4'h5);
        check("bounce_single", 16'(key_valid), 16'd0);
        keys = '0;
        wait_scans(4);

        // Table of press patterns: one entry each, lowest index wins
        for (int i = 0; i < 6; i++) begin
            sync_scan();
            keys = tbl[i].keys;
            wait_scans(5);
            pop_check("tbl_press", tbl[i].code);
            check("tbl_one_entry", 16'(key_valid), 16'd0);
            check("tbl_hold_code", 16'(key_code), 16'(tbl[i].code));
            keys = '0;
            wait_scans(5);
            check("tbl_release", 16'(key_valid), 16'd0);
        end

        // Push and pop on the same edge with one entry queued
        press_release(16'h0002);
        sync_scan();
        keys = 16'h0004;
        repeat (33) @(posedge clk);
        @(negedge clk);
        check("pp1_head_before", 16'(key_code), 16'h1);
        rd_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rd_en = 1'b0;
        check("pp1_valid", 16'(key_valid), 16'd1);
        check("pp1_head_after", 16'(key_code), 16'h2);
        keys = '0;
        wait_scans(4);
        pop_check("pp1_drain", 4'h2);
        check("pp1_empty", 16'(key_valid), 16'd0);

        // Fill, overflow, clear, then push+pop while full
        press_release(16'h0002);
        press_release(16'h0004);
        press_release(16'h0008);
        press_release(16'h0010);
        check("full_no_ovf", 16'(overflow), 16'd0);
        press_release(16'h0040);
        check("ovf_set", 16'(overflow), 16'd1);
        clr_ovf = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr_ovf = 1'b0;
        check("ovf_clr", 16'(overflow), 16'd0);
        sync_scan();
        keys = 16'h0100;
        repeat (33) @(posedge clk);
        @(negedge clk);
        check("ppf_head", 16'(key_code), 16'h1);
        rd_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rd_en = 1'b0;
        check("ppf_no_ovf", 16'(overflow), 16'd0);
        keys = '0;
        wait_scans(4);
        pop_check("drain_2", 4'h2);
        pop_check("drain_3", 4'h3);
        pop_check("drain_4", 4'h4);
        pop_check("drain_8", 4'h8);
        check("drain_empty", 16'(key_valid), 16'd0);

        // Reset mid-operation with a key still held
        press_release(16'h0080);
        sync_scan();
        keys = 16'h2000;
        wait_scans(4);
        check("pre_rst_head", 16'(key_code), 16'h7);
        resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        check("mid_rst_valid", 16'(key_valid), 16'd0);
        check("mid_rst_code", 16'(key_code), 16'd0);
        check("mid_rst_rows", 16'(rows), 16'(exp_rows[0]));
        wait_scans(5);
        pop_check("rst_requeue", 4'hD);
        check("rst_requeue_once", 16'(key_valid), 16'd0);
        wait_scans(4);
        check("rst_held_quiet", 16'(key_valid), 16'd0);
        keys = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/keypad_scan_fifo.md
Name: keypad_scan_fifo

Overview:
Upstream stage of the memory-mapped keypad read path. It drives the 4x4 keypad rows, samples the columns, and debounces the full 16-key map. Each new key press is encoded as a 4-bit code and queued in a small FIFO. The peripheral controller reads the FIFO head and pops it with a read strobe, so CPU polling latency never loses keystrokes.

Parameters:
SCAN_DIV, 50000, clk cycles each row is driven before its columns are sampled (>=2)
DEBOUNCE_SCANS, 4, consecutive identical full scans required before the stable map updates (>=1)
FIFO_DEPTH, 4, key-code entries buffered (power of 2, >=2)

Ports:
clk  in  1  system clock
resetn  in  1  synchronous active-low reset
cols  in  4  keypad columns, active-low (0 = pressed), externally pulled up
rows  out  4  keypad rows, one-hot active-low drive
rd_en  in  1  pop strobe from controller; one pop per cycle high while key_valid=1
clr_ovf  in  1  clears the overflow flag
key_code  out  4  FIFO head, code = row*4 + col
key_valid  out  1  FIFO non-empty
overflow  out  1  sticky flag: a press was dropped because the FIFO was full

Behaviour:
- Reset (resetn=0 at a clk edge):
  - div=0, row=0, rows=4'b1110.
  - snapshot, stable map and candidate map all 0; match count 0.
  - FIFO empty; key_valid=0, key_code=0, overflow=0.
  - Reset mid-scan or mid-FIFO discards everything.
- Scan:
  - div counts 0..SCAN_DIV-1.
  - At div==SCAN_DIV-1: snapshot[row*4+c] <= ~cols[c], row <= row+1 (wraps 3->0), div <= 0.
  - rows updates on the same edge, so each row is driven SCAN_DIV cycles before its sample.
- Scan complete: the sample edge of row 3.
  - On the next cycle, compare snapshot to the candidate map.
  - Equal: increment match count (saturating). Different: candidate <= snapshot, count <= 1.
  - When count reaches DEBOUNCE_SCANS and candidate != stable:
    - new_press = candidate & ~stable;
    - stable <= candidate.
  - Releases only clear stable bits and produce no event.
- Press event:
  - If new_press != 0, the lowest set index is pushed one cycle after stable updates.
  - Other simultaneous new presses are dropped. They are not re-pushed while held, because they are already in stable.
  - Press latency from first stable sample is DEBOUNCE_SCANS full scans plus 2 cycles.
- FIFO: first-word fall-through.
  - key_code shows the head combinationally from storage whenever key_valid=1; it holds its last value when empty.
  - rd_en with key_valid=1 pops on that edge. rd_en while empty is ignored.
  - Push while full: entry dropped, overflow <= 1.
  - Push and pop together when full: both happen, no overflow.
  - Push and pop together at count 1: count stays 1 and the head becomes the new code.
  - Pointers wrap modulo FIFO_DEPTH. A count register distinguishes full from empty.
- Overflow: clr_ovf clears it. If clr_ovf and a dropped push occur in the same cycle, set wins.

Optional Feature:
- Macro: KEYPAD_AUTOREPEAT_EN.
- Defined:
  - Two extra parameters: REPEAT_DELAY (default 32 scans) and REPEAT_RATE (default 8 scans).
  - While exactly one stable key stays held, its code is re-pushed after REPEAT_DELAY complete scans, then every REPEAT_RATE scans.
  - Any change to the stable map restarts the repeat counter.
  - Repeated pushes follow the same full/overflow rules.
- Undefined: no repeat logic and no extra parameters; each press yields exactly one entry.

Decomposition:
- Package keypad_pkg:
  - NUM_ROWS=4, NUM_COLS=4, KEYCODE_W=4;
  - typedef keycode_t (logic [3:0]) and keymap_t (logic [15:0]);
  - function lowest_index(keymap_t) returning keycode_t.
- One sub-module, key_fifo: parameterised FWFT FIFO with push, pop, full, empty, head. It is instantiated once. Scanning and debounce stay in the top.

Test Plan:
- Reset, with SCAN_DIV=4 and DEBOUNCE_SCANS=2 for all tests: hold resetn=0 for 3 cycles -> rows=1110, key_valid=0, overflow=0. Then rows steps 1110->1101->1011->0111->1110 every 4 cycles.
- Clean press: pull cols[2] low only while rows=1011 (key 10), held for 4 scans -> key_valid rises with key_code=4'hA; rd_en for 1 cycle -> key_valid=0; holding the key produces no second entry.
- Bounce: press key 5 (row1, col1) present in alternating scans for 6 scans, then steady -> no push until 2 identical consecutive scans, then exactly one entry 4'h5.
- Simultaneous press: keys 3 and 12 become stable in the same scan -> only 4'h3 is queued.
- Full/overflow: press and release keys 1,2,3,4,6 without reading -> FIFO holds 1,2,3,4 and overflow=1. Pop all -> 1,2,3,4 in order. clr_ovf -> overflow=0.
- Reset mid-operation: 2 entries queued, resetn=0 for 1 cycle -> key_valid=0, snapshot cleared, and a still-held key is re-debounced and queued once after reset.
